// File: rtl/lcd_refresh_ctrl_if.sv
// Purpose : bundles the message-buffer read port and the HD44780 pin bus of the LCD refresher.
// Latency : n/a (wires only); rdata is a zero-latency combinational read of raddr.
// Backpr. : none; the panel is paced purely by fixed cycle timing, there is no handshake.
// Ports   : raddr/rdata = buffer read port; lcd_data/lcd_rs/lcd_rw/lcd_en = panel pins;
//           frame_done = 1-cycle pulse once a full frame has been written.
interface lcd_refresh_ctrl_if;
  logic [4:0] raddr;
  logic [7:0] rdata;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       frame_done;

  // master = the refresh controller, slave = buffer + panel side
  modport master (
    output raddr, lcd_data, lcd_rs, lcd_rw, lcd_en, frame_done,
    input  rdata
  );
  modport slave (
    input  raddr, lcd_data, lcd_rs, lcd_rw, lcd_en, frame_done,
    output rdata
  );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// Purpose : power-up wait + HD44780 init, then endless refresh of a 16x2 panel from a 32-byte buffer.
// Latency : one write = 1 setup + E_HIGH_CYC enable + CHAR_WAIT_CYC (CLEAR_WAIT_CYC after 0x01) cycles.
// Backpr. : none; timing is open-loop, the panel is assumed to keep up with the programmed waits.
// Ports   : clk, rst (async, active-high); bus (master modport): raddr/rdata buffer read,
//           lcd_data/lcd_rs/lcd_rw/lcd_en panel pins, frame_done end-of-frame pulse.
module lcd_refresh_ctrl #(
  parameter int PWRUP_CYC      = 750000,
  parameter int E_HIGH_CYC     = 16,
  parameter int CHAR_WAIT_CYC  = 2500,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int REFRESH_CYC    = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_refresh_ctrl_if.master   bus
);

  localparam int WAIT_MAX = (CLEAR_WAIT_CYC > CHAR_WAIT_CYC) ? CLEAR_WAIT_CYC : CHAR_WAIT_CYC;
  localparam int PW = (PWRUP_CYC   > 1) ? $clog2(PWRUP_CYC)   : 1;
  localparam int EW = (E_HIGH_CYC  > 1) ? $clog2(E_HIGH_CYC)  : 1;
  localparam int WW = (WAIT_MAX    > 1) ? $clog2(WAIT_MAX)    : 1;
  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYC - 1);
  localparam logic [EW-1:0] EN_LAST  = EW'(E_HIGH_CYC - 1);
  localparam logic [WW-1:0] CHR_LAST = WW'(CHAR_WAIT_CYC - 1);
  localparam logic [WW-1:0] CLR_LAST = WW'(CLEAR_WAIT_CYC - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);

  typedef enum logic [2:0] {PWRUP, INIT, L1ADDR, L1CHR, L2ADDR, L2CHR, REFR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN_HI, PH_WAIT} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [3:0]    idx_q, idx_d;
  logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [EW-1:0] en_cnt_q, en_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RW-1:0] refr_cnt_q, refr_cnt_d;
  logic [4:0]    raddr_q, raddr_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_en_q, lcd_en_d;
  logic          frame_done_q, frame_done_d;

  // {rs, data} for write number i of state s; characters get the digit/space mapping.
  function automatic logic [8:0] write_word(input state_t s, input logic [3:0] i,
                                            input logic [7:0] rd);
    logic [8:0] w;
    w = 9'h000;
    case (s)
      INIT: begin
        case (i)
          4'd0:    w = {1'b0, 8'h38};
          4'd1:    w = {1'b0, 8'h0C};
          4'd2:    w = {1'b0, 8'h01};
          default: w = {1'b0, 8'h06};
        endcase
      end
      L1ADDR: w = {1'b0, 8'h80};
      L2ADDR: w = {1'b0, 8'hC0};
      L1CHR, L2CHR: begin
        if (rd < 8'h0A)      w = {1'b1, rd + 8'h30};
        else if (rd < 8'h20) w = {1'b1, 8'h20};
        else                 w = {1'b1, rd};
      end
      default: w = 9'h000;
    endcase
    return w;
  endfunction

  logic       go;
  state_t     nst;
  logic [3:0] nidx;
  logic       clear_wait;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    pwr_cnt_d    = pwr_cnt_q;
    en_cnt_d     = en_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    refr_cnt_d   = refr_cnt_q;
    raddr_d      = raddr_q;
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_en_d     = 1'b0;
    frame_done_d = 1'b0;
    go           = 1'b0;
    nst          = state_q;
    nidx         = 4'd0;
    // the clear command needs the long wait; everything else uses the short one
    clear_wait   = !lcd_rs_q && (lcd_data_q == 8'h01);

    case (state_q)
      PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin go = 1'b1; nst = INIT; end
        else pwr_cnt_d = pwr_cnt_q + PW'(1);
      end
      REFR: begin
        if (refr_cnt_q == REF_LAST) begin go = 1'b1; nst = L1ADDR; end
        else refr_cnt_d = refr_cnt_q + RW'(1);
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d  = PH_EN_HI;
            en_cnt_d = '0;
            lcd_en_d = 1'b1;
          end
          PH_EN_HI: begin
            if (en_cnt_q == EN_LAST) begin
              phase_d    = PH_WAIT;
              wait_cnt_d = '0;
              // advance the buffer address now so it is settled long before the next SETUP;
              // after the very last character it is cleared on entry to REFR instead
              if (state_q == L1CHR || (state_q == L2CHR && idx_q != 4'd15))
                raddr_d = raddr_q + 5'd1;
            end else begin
              en_cnt_d = en_cnt_q + EW'(1);
              lcd_en_d = 1'b1;
            end
          end
          PH_WAIT: begin
            if (wait_cnt_q == (clear_wait ? CLR_LAST : CHR_LAST)) begin
              go   = 1'b1;
              nidx = idx_q + 4'd1;
              case (state_q)
                INIT:   if (idx_q == 4'd3)  begin nst = L1ADDR; nidx = 4'd0; end
                L1ADDR: begin nst = L1CHR; nidx = 4'd0; end
                L1CHR:  if (idx_q == 4'd15) begin nst = L2ADDR; nidx = 4'd0; end
                L2ADDR: begin nst = L2CHR; nidx = 4'd0; end
                L2CHR: begin
                  if (idx_q == 4'd15) begin
                    go           = 1'b0;
                    state_d      = REFR;
                    refr_cnt_d   = '0;
                    raddr_d      = 5'd0;
                    frame_done_d = 1'b1;
                  end
                end
                default: ;
              endcase
            end else begin
              wait_cnt_d = wait_cnt_q + WW'(1);
            end
          end
          default: phase_d = PH_SETUP;
        endcase
      end
    endcase

    // starting a write: the edge that enters SETUP also registers data/rs
    if (go) begin
      state_d = nst;
      idx_d   = nidx;
      phase_d = PH_SETUP;
      {lcd_rs_d, lcd_data_d} = write_word(nst, nidx, bus.rdata);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PWRUP;
      phase_q      <= PH_SETUP;
      idx_q        <= '0;
      pwr_cnt_q    <= '0;
      en_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      refr_cnt_q   <= '0;
      raddr_q      <= '0;
      lcd_data_q   <= '0;
      lcd_rs_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      pwr_cnt_q    <= pwr_cnt_d;
      en_cnt_q     <= en_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      refr_cnt_q   <= refr_cnt_d;
      raddr_q      <= raddr_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_en_q     <= lcd_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.raddr      = raddr_q;
  assign bus.lcd_data   = lcd_data_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_en     = lcd_en_q;
  assign bus.frame_done = frame_done_q;

endmodule
